animation_stepper: RTL and testbench

Frame-rate animation engine that sits directly downstream of the speed controller. It detects the vsync rising edge that marks each new frame. On each such edge it advances a pattern phase by `step_size`, unless `paused` is set. The resulting phase, direction and frame pulse drive the pattern generators. Supports wrap-around or ping-pong (bounce) motion.

---
 rtl/animation_stepper.sv | 108 ++++++++++
 tb/tb_animation_stepper.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/animation_stepper.sv
// Frame-rate animation stepper: advances a pattern phase on every unpaused
// vsync rising edge, in wrap-around or ping-pong (bounce) motion.
module animation_stepper #(
   parameter int unsigned PHASE_W   = 10,
   parameter int unsigned PHASE_MAX = 639,
   parameter bit          BOUNCE    = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vsync,
   input  logic               paused,
   input  logic [2:0]         step_size,
   input  logic               restart,
   output logic               frame_tick,
   output logic [7:0]         frame_count,
   output logic [PHASE_W-1:0] phase,
   output logic               direction
);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   localparam logic [PHASE_W:0] MAX_X = (PHASE_W+1)'(PHASE_MAX);
   localparam logic [PHASE_W:0] ONE_X = (PHASE_W+1)'(1);

   logic               vsync_q;
   logic               tick_q, tick_d;
   logic [7:0]         count_q, count_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   dir_e               dir_q, dir_d;

   logic               rise;
   logic [PHASE_W:0]   s_x, ph_x, t_x;

   assign rise = vsync & ~vsync_q;
   assign s_x  = (step_size == 3'd0) ? ONE_X : (PHASE_W+1)'(step_size);
   assign ph_x = {1'b0, phase_q};
   assign t_x  = ph_x + s_x;

   always_comb begin
      phase_d = phase_q;
      dir_d   = dir_q;
      tick_d  = 1'b0;
      count_d = count_q;

      if (rise) begin
         count_d = count_q + 8'd1;
      end

      if (restart) begin
         phase_d = '0;
         dir_d   = DIR_UP;
      end else if (rise && !paused) begin
         tick_d = 1'b1;
         if (!BOUNCE) begin
            dir_d = DIR_UP;
            if (t_x > MAX_X) phase_d = PHASE_W'(t_x - MAX_X - ONE_X);
            else             phase_d = PHASE_W'(t_x);
         end else if (dir_q == DIR_UP) begin
            // s <= 7 <= PHASE_MAX, so a single reflection off the top is enough
            if (t_x < MAX_X) begin
               phase_d = PHASE_W'(t_x);
            end else if (t_x == MAX_X) begin
               phase_d = PHASE_W'(MAX_X);
               dir_d   = DIR_DOWN;
            end else begin
               phase_d = PHASE_W'(MAX_X + MAX_X - t_x);
               dir_d   = DIR_DOWN;
            end
         end else begin
            if (ph_x > s_x) begin
               phase_d = PHASE_W'(ph_x - s_x);
            end else if (ph_x == s_x) begin
               phase_d = '0;
               dir_d   = DIR_UP;
            end else begin
               phase_d = PHASE_W'(s_x - ph_x);
               dir_d   = DIR_UP;
            end
         end
      end
   end

   // vsync_q resets high so a vsync already high at release is not an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_q <= 1'b1;
         tick_q  <= 1'b0;
         count_q <= '0;
         phase_q <= '0;
         dir_q   <= DIR_UP;
      end else begin
         vsync_q <= vsync;
         tick_q  <= tick_d;
         count_q <= count_d;
         phase_q <= phase_d;
         dir_q   <= dir_d;
      end
   end

   assign frame_tick  = tick_q;
   assign frame_count = count_q;
   assign phase       = phase_q;
   assign direction   = dir_q;

endmodule

// File: tb/tb_animation_stepper.sv
// Directed bench: a wrap-mode and a bounce-mode stepper share the same stimulus.
module tb_animation_stepper;

   logic       clk = 1'b0;
   logic       rst, vsync, paused, restart;
   logic [2:0] step_size;

   logic       w_tick, b_tick, w_dir, b_dir;
   logic [7:0] w_cnt, b_cnt;
   logic [9:0] w_ph, b_ph;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [7:0]  exp_cnt;

   always #5 clk = ~clk;

   animation_stepper #(.PHASE_W(10), .PHASE_MAX(639), .BOUNCE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .vsync(vsync), .paused(paused), .step_size(step_size),
      .restart(restart), .frame_tick(w_tick), .frame_count(w_cnt), .phase(w_ph),
      .direction(w_dir)
   );

   animation_stepper #(.PHASE_W(10), .PHASE_MAX(639), .BOUNCE(1'b1)) u_bnc (
      .clk(clk), .rst(rst), .vsync(vsync), .paused(paused), .step_size(step_size),
      .restart(restart), .frame_tick(b_tick), .frame_count(b_cnt), .phase(b_ph),
      .direction(b_dir)
   );

   typedef struct {
      logic       vs;
      logic       pa;
      logic [2:0] st;
      logic       rs;
      logic [9:0] ph;
      logic       tk;
      logic [7:0] cnt;
      logic       dir;
   } vec_t;

   vec_t tbl[24];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic frame(input logic [2:0] st);
      vsync = 1'b0; paused = 1'b0; restart = 1'b0; step_size = st;
      cyc();
      vsync = 1'b1;
      cyc();
      exp_cnt = exp_cnt + 8'd1;
   endtask

   task automatic do_restart();
      vsync = 1'b0; restart = 1'b1;
      cyc();
      restart = 1'b0;
   endtask

   initial begin
      //           vs    pa    st    rs    ph      tk    cnt    dir
      tbl[0]  = '{1'b1, 1'b0, 3'd3, 1'b0, 10'd0,  1'b0, 8'd0,  1'b0};
      tbl[1]  = '{1'b0, 1'b0, 3'd3, 1'b0, 10'd0,  1'b0, 8'd0,  1'b0};
      tbl[2]  = '{1'b1, 1'b0, 3'd3, 1'b0, 10'd3,  1'b1, 8'd1,  1'b0};
      tbl[3]  = '{1'b1, 1'b0, 3'd3, 1'b0, 10'd3,  1'b0, 8'd1,  1'b0};
      tbl[4]  = '{1'b0, 1'b0, 3'd0, 1'b0, 10'd3,  1'b0, 8'd1,  1'b0};
      tbl[5]  = '{1'b1, 1'b0, 3'd0, 1'b0, 10'd4,  1'b1, 8'd2,  1'b0};
      tbl[6]  = '{1'b0, 1'b1, 3'd7, 1'b0, 10'd4,  1'b0, 8'd2,  1'b0};
      tbl[7]  = '{1'b1, 1'b1, 3'd7, 1'b0, 10'd4,  1'b0, 8'd3,  1'b0};
      tbl[8]  = '{1'b0, 1'b1, 3'd7, 1'b0, 10'd4,  1'b0, 8'd3,  1'b0};
      tbl[9]  = '{1'b1, 1'b0, 3'd7, 1'b0, 10'd11, 1'b1, 8'd4,  1'b0};
      tbl[10] = '{1'b0, 1'b1, 3'd7, 1'b0, 10'd11, 1'b0, 8'd4,  1'b0};
      tbl[11] = '{1'b1, 1'b1, 3'd7, 1'b0, 10'd11, 1'b0, 8'd5,  1'b0};
      tbl[12] = '{1'b0, 1'b1, 3'd7, 1'b0, 10'd11, 1'b0, 8'd5,  1'b0};
      tbl[13] = '{1'b1, 1'b1, 3'd7, 1'b0, 10'd11, 1'b0, 8'd6,  1'b0};
      tbl[14] = '{1'b0, 1'b0, 3'd7, 1'b0, 10'd11, 1'b0, 8'd6,  1'b0};
      tbl[15] = '{1'b1, 1'b0, 3'd7, 1'b0, 10'd18, 1'b1, 8'd7,  1'b0};
      tbl[16] = '{1'b0, 1'b0, 3'd7, 1'b0, 10'd18, 1'b0, 8'd7,  1'b0};
      tbl[17] = '{1'b1, 1'b0, 3'd7, 1'b1, 10'd0,  1'b0, 8'd8,  1'b0};
      tbl[18] = '{1'b0, 1'b0, 3'd5, 1'b0, 10'd0,  1'b0, 8'd8,  1'b0};
      tbl[19] = '{1'b1, 1'b0, 3'd5, 1'b0, 10'd5,  1'b1, 8'd9,  1'b0};
      tbl[20] = '{1'b0, 1'b0, 3'd5, 1'b0, 10'd5,  1'b0, 8'd9,  1'b0};
      tbl[21] = '{1'b1, 1'b0, 3'd5, 1'b0, 10'd10, 1'b1, 8'd10, 1'b0};
      tbl[22] = '{1'b0, 1'b0, 3'd5, 1'b0, 10'd10, 1'b0, 8'd10, 1'b0};
      tbl[23] = '{1'b1, 1'b0, 3'd5, 1'b0, 10'd15, 1'b1, 8'd11, 1'b0};

      rst = 1'b1; vsync = 1'b1; paused = 1'b0; restart = 1'b0; step_size = 3'd3;
      cyc();
      cyc();
      chk("reset_w_phase", 32'(w_ph), 32'd0);
      chk("reset_w_tick",  32'(w_tick), 32'd0);
      chk("reset_w_count", 32'(w_cnt), 32'd0);
      chk("reset_b_phase", 32'(b_ph), 32'd0);
      chk("reset_b_dir",   32'(b_dir), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 24; i++) begin
         vsync = tbl[i].vs; paused = tbl[i].pa; step_size = tbl[i].st; restart = tbl[i].rs;
         cyc();
         chk($sformatf("vec%0d_w_phase", i), 32'(w_ph),   32'(tbl[i].ph));
         chk($sformatf("vec%0d_w_tick", i),  32'(w_tick), 32'(tbl[i].tk));
         chk($sformatf("vec%0d_w_count", i), 32'(w_cnt),  32'(tbl[i].cnt));
         chk($sformatf("vec%0d_w_dir", i),   32'(w_dir),  32'd0);
         chk($sformatf("vec%0d_b_phase", i), 32'(b_ph),   32'(tbl[i].ph));
         chk($sformatf("vec%0d_b_dir", i),   32'(b_dir),  32'(tbl[i].dir));
         chk($sformatf("vec%0d_b_count", i), 32'(b_cnt),  32'(tbl[i].cnt));
      end
      restart = 1'b0;
      exp_cnt = 8'd11;

      // wrap across the top, bounce reflecting off it
      do_restart();
      repeat (90) frame(3'd7);
      frame(3'd6);
      chk("A_w_636", 32'(w_ph), 32'd636);
      chk("A_b_636", 32'(b_ph), 32'd636);
      frame(3'd6);
      chk("A_w_wrap", 32'(w_ph), 32'd2);
      chk("A_w_tick1", 32'(w_tick), 32'd1);
      chk("A_w_dir", 32'(w_dir), 32'd0);
      chk("A_b_reflect", 32'(b_ph), 32'd636);
      chk("A_b_dir", 32'(b_dir), 32'd1);
      cyc();
      chk("A_w_tick0", 32'(w_tick), 32'd0);
      chk("A_count", 32'(w_cnt), 32'(exp_cnt));

      // bounce up-leg from 637, down leg, bottom turnaround from 3
      do_restart();
      repeat (90) frame(3'd7);
      frame(3'd7);
      chk("B_b_637", 32'(b_ph), 32'd637);
      frame(3'd5);
      chk("B_b_up_leg", 32'(b_ph), 32'd636);
      chk("B_b_up_dir", 32'(b_dir), 32'd1);
      chk("B_w_2", 32'(w_ph), 32'd2);
      repeat (90) frame(3'd7);
      frame(3'd3);
      chk("B_b_3", 32'(b_ph), 32'd3);
      chk("B_b_3dir", 32'(b_dir), 32'd1);
      frame(3'd5);
      chk("B_b_turn", 32'(b_ph), 32'd2);
      chk("B_b_turndir", 32'(b_dir), 32'd0);
      chk("B_w_0", 32'(w_ph), 32'd0);

      // exact hit on PHASE_MAX
      do_restart();
      repeat (90) frame(3'd7);
      frame(3'd4);
      frame(3'd5);
      chk("C_w_639", 32'(w_ph), 32'd639);
      chk("C_b_639", 32'(b_ph), 32'd639);
      chk("C_b_dir", 32'(b_dir), 32'd1);
      frame(3'd0);
      chk("C_w_wrap0", 32'(w_ph), 32'd0);
      chk("C_b_638", 32'(b_ph), 32'd638);
      chk("C_b_dir2", 32'(b_dir), 32'd1);
      chk("C_count", 32'(b_cnt), 32'(exp_cnt));

      // reset landing on a rise cycle, then release with vsync high
      vsync = 1'b0;
      cyc();
      rst = 1'b1; vsync = 1'b1;
      cyc();
      chk("D_w_phase", 32'(w_ph), 32'd0);
      chk("D_w_tick", 32'(w_tick), 32'd0);
      chk("D_w_count", 32'(w_cnt), 32'd0);
      chk("D_b_phase", 32'(b_ph), 32'd0);
      chk("D_b_dir", 32'(b_dir), 32'd0);
      rst = 1'b0;
      cyc();
      chk("D_nospur_count", 32'(w_cnt), 32'd0);
      chk("D_nospur_tick", 32'(w_tick), 32'd0);
      exp_cnt = 8'd0;
      frame(3'd3);
      chk("D_first_count", 32'(w_cnt), 32'd1);
      chk("D_first_phase", 32'(b_ph), 32'd3);
      chk("D_first_tick", 32'(b_tick), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
